// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
// Optional even parity is enabled by defining UART_TX_PARITY_EN.
package uart_tx_mmio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Depth must be a power of two so the pointers wrap naturally.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [7:0]  wdata_i,
    output logic [7:0]  rdata_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("tx_fifo: DEPTH must be a power of two in 2..64");
    end

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a store-fed FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit before stop.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int CLK_FREQ   = 23000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       ovf
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    if (CPB < 2) begin : g_bad_baud
        $error("uart_tx_mmio: CLK_FREQ/BAUD must be at least 2");
    end

    state_e        state_q;
    state_e        state_d;
    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          tx_q;
    logic          tx_d;
    logic          ovf_q;
    logic          ovf_d;

    logic          push;
    logic          pop;
    logic          drop;
    logic          bit_done;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bit_done = (baud_q == BW'(CPB - 1));

    // A pop on this edge frees a slot, so a write to a full FIFO still lands.
    assign push = wr_en && !rst && (!fifo_full || pop);
    assign drop = wr_en && !rst && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;
        if (state_q != IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_rdata;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line register follows the current state, one edge behind the FSM.
    always_comb begin
        tx_d = IDLE_LINE;
        unique case (state_q)
            IDLE:    tx_d = IDLE_LINE;
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^data_q;
`endif
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LINE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= IDLE_LINE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || (fifo_count != '0);
    assign full = fifo_full;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized bench for uart_tx_mmio against a timing-rule line model.
// Honours UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_tx_mmio;

    localparam int CF    = 16;
    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int CPB   = CF / BD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx;
    logic       busy;
    logic       full;
    logic       ovf;

    uart_tx_mmio #(
        .CLK_FREQ   (CF),
        .BAUD       (BD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .tx      (tx),
        .busy    (busy),
        .full    (full),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [7:0] mq[$];
    bit         m_ovf  = 1'b0;
    bit         m_act  = 1'b0;
    int         m_last = 0;
    logic [7:0] m_byte = '0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got=%0h want=%0h", tag, n, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic exp_tx();
        if (m_act && n >= m_last + 1 && n <= m_last + FRAME)
            return frame_bit(m_byte, (n - m_last - 1) / CPB);
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (mq.size() > 0) || (m_act && n < m_last + FRAME);
    endfunction

    // One clock: drive, clock, advance the model, then compare all outputs.
    task automatic step(input logic w, input logic [7:0] d,
                        input logic c, input logic r);
        bit pop;
        bit was_full;
        bit dropped;
        rst     = r;
        wr_en   = w;
        wr_data = d;
        clr_ovf = c;
        @(posedge clk);
        n++;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_act = 1'b0;
        end else begin
            pop      = (mq.size() > 0) && (!m_act || n >= m_last + FRAME);
            was_full = (mq.size() == DEPTH);
            dropped  = 1'b0;
            if (pop) begin
                m_byte = mq.pop_front();
                m_last = n;
                m_act  = 1'b1;
            end
            if (w) begin
                if (!was_full || pop) mq.push_back(d);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        #1;
        chk("tx", tx, exp_tx());
        chk("busy", busy, exp_busy());
        chk("full", full, mq.size() == DEPTH);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int full_cnt;
        int wr_edge;
        bit hit;
        int p;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);

        // single byte: latency, bit pattern, busy window
        step(1'b1, 8'h55, 1'b0, 1'b0);
        wr_edge = n;
        busy_cnt = busy ? 1 : 0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lat_e1_high", tx, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lat_e2_low", tx, 0);
        busy_cnt += 2;
        for (int i = 0; i < FRAME + 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (busy) busy_cnt++;
        end
        chk("s1_busy_len", busy_cnt, FRAME + 1);
        chk("s1_edge", n - wr_edge, FRAME + 12);

        // three back-to-back frames
        full_cnt = 0;
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3 * FRAME + 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (full) full_cnt++;
        end
        chk("s2_full_seen", full_cnt, 0);

        // overflow on the sixth write, then clear
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("s3_ovf", ovf, 1);
        chk("s3_full", full, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s3_clr", ovf, 0);
        idle(5 * FRAME + 10);

        // write exactly on the pop edge while full
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            if (n + 1 == m_last + FRAME && full) begin
                step(1'b1, 8'h99, 1'b0, 1'b0);
                hit = 1'b1;
            end else begin
                step(1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        chk("s4_sync", hit, 1);
        chk("s4_ovf", ovf, 0);
        chk("s4_full", full, 1);
        idle(6 * FRAME + 10);

        // reset in the middle of a data bit
        step(1'b1, 8'h81, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        while (n < m_last + 1 + 3 * CPB + 1) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b1);
        chk("s5_tx", tx, 1);
        chk("s5_busy", busy, 0);
        idle(2 * FRAME);

`ifdef UART_TX_PARITY_EN
        step(1'b1, 8'h07, 1'b0, 1'b0);
        idle(9 * CPB + 2);
        chk("par_07", tx, 1);
        idle(FRAME);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        idle(9 * CPB + 2);
        chk("par_03", tx, 0);
        idle(FRAME);
`endif

        // random traffic with varying write rate
        for (int blk = 0; blk < 8; blk++) begin
            p = $urandom_range(1, 40);
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, p - 1) == 0,
                     8'($urandom),
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 699) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 23000000, meaning cpu_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries; power of two, 2 to 64.
REQ-004 The block SHALL have port clk  in  1  the CPU clock; the one clock of the block, all logic on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port wr_en  in  1  single-cycle MMIO store strobe (ioWrite to the TX data address).
REQ-007 The block SHALL have port wr_data  in  8  byte to transmit (low byte of the store data).
REQ-008 The block SHALL have port clr_ovf  in  1  clears the overflow flag.
REQ-009 The block SHALL have port tx  out  1  serial line, idle high, driven from a register.
REQ-010 The block SHALL have port busy  out  1  FIFO not empty or frame in progress.
REQ-011 The block SHALL have port full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-012 The block SHALL have port ovf  out  1  sticky flag: a write was dropped.

Function
REQ-013 The bit period SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD clk cycles, integer division, truncated; CLKS_PER_BIT < 2 is an elaboration error.
REQ-014 The frame SHALL be LSB first, 8N1: start 0, d0..d7, stop 1.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY (only with the macro), STOP.
REQ-016 Transitions: IDLE->START when the FIFO is not empty (pop same edge); START->DATA after 1 bit; DATA->PARITY/STOP after 8 bits; STOP->START if the FIFO is not empty (pop), else ->IDLE, after 1 bit.
REQ-017 Frames SHALL be back-to-back: no idle cycles between the stop bit and the next start bit.
REQ-018 Latency: for a write to an empty FIFO with the FSM in IDLE, tx SHALL fall on the 2nd rising edge after the edge sampling wr_en.
REQ-019 A write when full SHALL be dropped and set ovf, except when a pop occurs on the same edge; that write SHALL be accepted.
REQ-020 A write and a pop on the same edge with the FIFO non-full SHALL leave the count unchanged.
REQ-021 clr_ovf SHALL clear ovf next edge; clr_ovf coinciding with a dropped write SHALL leave ovf set (set wins).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-023 busy, full and ovf SHALL be registered or derived from registers only, with no combinational path from wr_en.

Reset
REQ-024 On rst: tx=1, busy=0, full=0, ovf=0, FSM=IDLE, FIFO empty, bit and baud counters 0.
REQ-025 rst mid-frame SHALL abort the frame and drive tx high on the next edge; queued bytes are discarded.
REQ-026 wr_en asserted during rst SHALL be ignored.

Configuration
REQ-027 With UART_TX_PARITY_EN defined, the block SHALL insert one even-parity bit (XOR of d0..d7) between d7 and stop; frame = 11 bits.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame = 10 bits.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the START/STOP bit constants and a CLKS_PER_BIT helper function.
REQ-030 The FIFO SHALL be a sub-module named tx_fifo (sync FIFO, push/pop/full/empty/count); the FSM and baud counter SHALL stay in uart_tx_mmio.

Verification
REQ-031 Scenario 1: CLK_FREQ=16, BAUD=4, write 0x55 -> tx falls at edge +2; the line reads 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; busy drops after 40 cycles.
REQ-032 Scenario 2: write 0xA3, 0x0F, 0xFF on consecutive cycles -> three frames back-to-back with no idle gap, in order; full never asserts.
REQ-033 Scenario 3: FIFO_DEPTH=4, 6 writes in 6 cycles while the first frame sends -> 5 bytes are transmitted (1 popped, 4 queued), the 6th is dropped and ovf=1; clr_ovf -> ovf=0.
REQ-034 Scenario 4: full FIFO, wr_en on the pop edge at the end of STOP -> write accepted, ovf stays 0.
REQ-035 Scenario 5: rst asserted mid-DATA of 0x81 -> tx=1 next edge, busy=0, no further frames.
REQ-036 Scenario 6 (UART_TX_PARITY_EN): write 0x07 -> parity bit 1, 11-bit frame; write 0x03 -> parity bit 0.
